// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkg
// Purpose  : Shared types and constants for the UART receive front end.
//            Holds the receiver FSM state type, FIFO sizing, the bit
//            positions of the error flags inside a FIFO entry, and the
//            expected-parity helper used by the deframer.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package uart_rx_pkg;

  localparam int RX_FIFO_DEPTH = 16;
  localparam int RX_WORD_W     = 11;

  // FIFO entry layout: {break, parity_err, framing_err, data[7:0]}
  localparam int BRK_BIT = 10;
  localparam int PE_BIT  = 9;
  localparam int FE_BIT  = 8;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    START     = 4'd1,
    DATA      = 4'd2,
    PARITY    = 4'd3,
    STOP      = 4'd4,
    WAIT_HIGH = 4'd5
  } rx_state_t;

  // Parity bit the transmitter should have sent for this character.
  // Unused upper data bits are already zero, so they do not disturb the XOR.
  function automatic logic expected_parity(input logic [7:0] data,
                                           input logic [7:0] lcr);
    logic x;
    x = ^data;
    if (lcr[5]) begin
      return ~lcr[4];          // stick parity
    end else if (lcr[4]) begin
      return x;                // even parity
    end else begin
      return ~x;               // odd parity
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Purpose  : Bundle between the UART register file and the receive front end.
// Ports    : register-file to receiver : rx_enable, LCR, srx, rx_fifo_re,
//                                        rx_fifo_clear
//            receiver to register-file : rx_data_out, rx_fifo_count,
//                                        rx_fifo_empty, rx_fifo_full,
//                                        push_rx_fifo, rx_idle, rx_overrun,
//                                        parity_error, framing_error,
//                                        break_error, rx_state
//            modport master : register-file side
//            modport slave  : receiver side
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int WORD_W     = 11
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              rx_enable;
  logic [7:0]        LCR;
  logic              srx;
  logic              rx_fifo_re;
  logic              rx_fifo_clear;

  logic [WORD_W-1:0] rx_data_out;
  logic [CNT_W-1:0]  rx_fifo_count;
  logic              rx_fifo_empty;
  logic              rx_fifo_full;
  logic              push_rx_fifo;
  logic              rx_idle;
  logic              rx_overrun;
  logic              parity_error;
  logic              framing_error;
  logic              break_error;
  logic [3:0]        rx_state;

  modport master (
    output rx_enable, LCR, srx, rx_fifo_re, rx_fifo_clear,
    input  rx_data_out, rx_fifo_count, rx_fifo_empty, rx_fifo_full,
           push_rx_fifo, rx_idle, rx_overrun, parity_error, framing_error,
           break_error, rx_state
  );

  modport slave (
    input  rx_enable, LCR, srx, rx_fifo_re, rx_fifo_clear,
    output rx_data_out, rx_fifo_count, rx_fifo_empty, rx_fifo_full,
           push_rx_fifo, rx_idle, rx_overrun, parity_error, framing_error,
           break_error, rx_state
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive FIFO holding characters with their error flags.
//            Priority: clear > push-while-full (drop, set overrun) >
//            simultaneous push/pop > pop-while-empty (ignored).
//            Overrun is sticky and cleared by a pop strobe or a clear.
// Ports    : clk, rst      clock, asynchronous active-high reset
//            i_clear       synchronous flush
//            i_push/i_wdata write strobe and entry
//            i_pop         read strobe
//            o_rdata       head entry, zero when empty
//            o_count       occupancy 0..FIFO_DEPTH
//            o_empty/o_full status flags
//            o_overrun     sticky overrun flag
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int WORD_W     = 11,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               i_clear,
  input  wire               i_push,
  input  wire  [WORD_W-1:0] i_wdata,
  input  wire               i_pop,
  output logic [WORD_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overrun
);

  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_empty;
  logic              w_full;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (i_clear) begin
      // Flush wins over everything, including a push in the same cycle.
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      w_rd_en = i_pop && !w_empty;
      // When full, a write is only possible because a pop frees a slot.
      w_wr_en = i_push && (!w_full || i_pop);
      if (i_push && w_full && !i_pop) begin
        overrun_d = 1'b1;
      end else if (i_pop) begin
        overrun_d = 1'b0;
      end
      if (w_wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_rd_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(w_wr_en) - CNT_W'(w_rd_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset; its contents are only visible when count > 0.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= i_wdata;
    end
  end

  assign o_rdata   = w_empty ? '0 : mem_q[rd_ptr_q];
  assign o_count   = count_q;
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_overrun = overrun_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : UART receive front end. Synchronizes srx, oversamples at 16x
//            using the rx_enable baud tick, deframes characters according to
//            LCR (5..8 data bits, optional even/odd/stick parity, one stop
//            bit checked) and stores {break, parity_err, framing_err, data}
//            in a FIFO.
// Ports    : PCLK     clock, rising edge
//            PRESET   asynchronous active-high reset
//            bus      uart_rx_if.slave: rx_enable, LCR, srx, rx_fifo_re,
//                     rx_fifo_clear in; FIFO head/status, push pulse,
//                     error flags, idle, overrun and debug state out
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_deserializer
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = RX_FIFO_DEPTH,
  parameter int WORD_W     = RX_WORD_W
) (
  input  wire       PCLK,
  input  wire       PRESET,
  uart_rx_if.slave  bus
);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  rx_state_t         state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        data_q, data_d;
  logic              par_bit_q, par_bit_d;
  logic              par_err_q, par_err_d;
  logic              push_q, push_d;
  logic              pe_q, pe_d;
  logic              fe_q, fe_d;
  logic              brk_q, brk_d;
  logic [WORD_W-1:0] entry_q, entry_d;

  logic              w_s;
  logic [2:0]        w_last_bit;
  logic              w_exp_par;
  logic              w_brk;
  logic              w_unused_lcr;

  assign w_s          = sync2_q;
  // Index of the final data bit: 4 for 5-bit words up to 7 for 8-bit words.
  assign w_last_bit   = 3'd4 + {1'b0, bus.LCR[1:0]};
  assign w_exp_par    = expected_parity(data_q, bus.LCR);
  assign w_unused_lcr = ^{bus.LCR[7:6], bus.LCR[2]};

  always_comb begin
    sync1_d   = bus.srx;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_bit_d = par_bit_q;
    par_err_d = par_err_q;
    entry_d   = entry_q;
    push_d    = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;
    brk_d     = 1'b0;
    w_brk     = 1'b0;

    if (bus.rx_enable) begin
      // The tick counter free-runs mod 16 inside a frame so the sample
      // point lands 16 ticks after the previous one.
      cnt_d = cnt_q + 4'd1;
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!w_s) begin
            state_d = START;
          end
        end
        START: begin
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (!w_s) begin
              state_d   = DATA;
              bit_idx_d = '0;
              data_d    = '0;
              par_bit_d = 1'b0;
              par_err_d = 1'b0;
            end else begin
              // Line went back high by mid-start: treat as a glitch.
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (cnt_q == 4'd15) begin
            data_d[bit_idx_q] = w_s;
            if (bit_idx_q == w_last_bit) begin
              state_d = bus.LCR[3] ? PARITY : STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (cnt_q == 4'd15) begin
            par_bit_d = w_s;
            par_err_d = (w_s != w_exp_par);
            state_d   = STOP;
          end
        end
        STOP: begin
          if (cnt_q == 4'd15) begin
            // Break: every bit of the frame, including parity and stop,
            // was low. The error flags are suppressed for a break entry.
            w_brk   = (data_q == 8'h00) && (!bus.LCR[3] || !par_bit_q) && !w_s;
            push_d  = 1'b1;
            brk_d   = w_brk;
            pe_d    = par_err_q && !w_brk;
            fe_d    = !w_s && !w_brk;
            entry_d = '0;
            entry_d[BRK_BIT] = w_brk;
            entry_d[PE_BIT]  = par_err_q && !w_brk;
            entry_d[FE_BIT]  = !w_s && !w_brk;
            entry_d[7:0]     = data_q;
            state_d = w_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line is released so a long break yields
          // only one entry.
          cnt_d = '0;
          if (w_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      entry_q   <= '0;
      push_q    <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
      entry_q   <= entry_d;
      push_q    <= push_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WORD_W     (WORD_W)
  ) u_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .i_clear   (bus.rx_fifo_clear),
    .i_push    (push_q),
    .i_wdata   (entry_q),
    .i_pop     (bus.rx_fifo_re),
    .o_rdata   (bus.rx_data_out),
    .o_count   (bus.rx_fifo_count),
    .o_empty   (bus.rx_fifo_empty),
    .o_full    (bus.rx_fifo_full),
    .o_overrun (bus.rx_overrun)
  );

  assign bus.push_rx_fifo  = push_q;
  assign bus.parity_error  = pe_q;
  assign bus.framing_error = fe_q;
  assign bus.break_error   = brk_q;
  assign bus.rx_idle       = (state_q == IDLE);
  assign bus.rx_state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Purpose  : Self-checking bench for uart_rx_deserializer. Frames are driven
//            at 16 ticks per bit with rx_enable every 4 PCLK; expected FIFO
//            entries come from a frame-level model and a queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_deserializer;
  import uart_rx_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_if #(.FIFO_DEPTH(16), .WORD_W(11)) bus ();

  uart_rx_deserializer #(.FIFO_DEPTH(16), .WORD_W(11)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: FIFO contents and sticky overrun
  logic [10:0] mq [$];
  logic        m_ovr = 1'b0;

  // Push monitor
  int          push_seen = 0;
  logic [2:0]  flag_log [$];

  // Baud tick: one PCLK high out of every four
  initial begin
    bus.rx_enable = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.rx_enable = 1'b1;
      @(negedge clk);
      bus.rx_enable = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.push_rx_fifo === 1'b1) begin
      push_seen++;
      flag_log.push_back({bus.break_error, bus.parity_error, bus.framing_error});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (bus.rx_enable !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive(input logic v, input int ticks);
    @(negedge clk);
    bus.srx = v;
    wait_ticks(ticks);
  endtask

  // Expected entry from the character-format rules
  function automatic logic [10:0] model_entry(input logic [7:0] d, input logic [7:0] lcr,
                                              input logic pbit, input logic stop);
    int          n;
    int          ones;
    logic [7:0]  dm;
    logic        want;
    logic        pe;
    n    = 5 + int'(lcr[1:0]);
    dm   = d & 8'((1 << n) - 1);
    ones = $countones(dm);
    if (lcr[5])      want = !lcr[4];
    else if (lcr[4]) want = (ones % 2) == 1;
    else             want = (ones % 2) == 0;
    pe = lcr[3] && (pbit != want);
    if (dm == 8'h00 && (!lcr[3] || !pbit) && !stop) return 11'h400;
    return {1'b0, pe, !stop, dm};
  endfunction

  task automatic model_push(input logic [10:0] e);
    if (mq.size() < 16) mq.push_back(e);
    else m_ovr = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [7:0] lcr,
                            input logic pbit, input logic stop);
    int n;
    n = 5 + int'(lcr[1:0]);
    drive(1'b0, 16);
    for (int k = 0; k < n; k++) drive(d[k], 16);
    if (lcr[3]) drive(pbit, 16);
    drive(stop, 16);
    drive(1'b1, 8);
  endtask

  task automatic send_and_check(input string tag, input logic [7:0] d, input logic [7:0] lcr,
                                input logic pbit, input logic stop);
    int          n0;
    logic [10:0] e;
    logic [2:0]  f;
    bus.LCR = lcr;
    n0 = push_seen;
    e  = model_entry(d, lcr, pbit, stop);
    send_frame(d, lcr, pbit, stop);
    @(negedge clk);
    chk({tag, "/pushes"}, 32'(push_seen - n0), 32'd1);
    f = 3'bxxx;
    while (flag_log.size() > 0) f = flag_log.pop_front();
    chk({tag, "/flags"}, 32'(f), 32'(e[10:8]));
    model_push(e);
  endtask

  task automatic check_fifo(input string tag);
    logic [10:0] head;
    head = (mq.size() > 0) ? mq[0] : 11'h000;
    chk({tag, "/count"},   32'(bus.rx_fifo_count), 32'(mq.size()));
    chk({tag, "/empty"},   32'(bus.rx_fifo_empty), 32'(mq.size() == 0));
    chk({tag, "/full"},    32'(bus.rx_fifo_full),  32'(mq.size() == 16));
    chk({tag, "/head"},    32'(bus.rx_data_out),   32'(head));
    chk({tag, "/overrun"}, 32'(bus.rx_overrun),    32'(m_ovr));
  endtask

  task automatic pop_fifo();
    @(negedge clk);
    bus.rx_fifo_re = 1'b1;
    @(negedge clk);
    bus.rx_fifo_re = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    m_ovr = 1'b0;
  endtask

  initial begin
    int          n0;
    logic [7:0]  lcr;
    logic [7:0]  d;
    rst               = 1'b1;
    bus.srx           = 1'b1;
    bus.LCR           = 8'h03;
    bus.rx_fifo_re    = 1'b0;
    bus.rx_fifo_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst/idle",    32'(bus.rx_idle),        32'd1);
    chk("rst/state",   32'(bus.rx_state),       32'(IDLE));
    chk("rst/empty",   32'(bus.rx_fifo_empty),  32'd1);
    chk("rst/full",    32'(bus.rx_fifo_full),   32'd0);
    chk("rst/count",   32'(bus.rx_fifo_count),  32'd0);
    chk("rst/dout",    32'(bus.rx_data_out),    32'd0);
    chk("rst/push",    32'(bus.push_rx_fifo),   32'd0);
    chk("rst/overrun", 32'(bus.rx_overrun),     32'd0);
    chk("rst/flags",   32'({bus.break_error, bus.parity_error, bus.framing_error}), 32'd0);

    // 8N1 0xA5
    wait_ticks(4);
    send_and_check("a5", 8'hA5, 8'h03, 1'b0, 1'b1);
    chk("a5/entry", 32'(bus.rx_data_out), 32'h0A5);
    check_fifo("a5");
    pop_fifo();
    check_fifo("a5pop");

    // Even parity, wrong then right parity bit
    send_and_check("par1", 8'h3C, 8'h1B, 1'b1, 1'b1);
    chk("par1/entry", 32'(bus.rx_data_out), 32'h23C);
    pop_fifo();
    send_and_check("par0", 8'h3C, 8'h1B, 1'b0, 1'b1);
    chk("par0/entry", 32'(bus.rx_data_out), 32'h03C);
    pop_fifo();
    check_fifo("par");

    // Break: line held low for 300 ticks
    bus.LCR = 8'h03;
    n0 = push_seen;
    flag_log.delete();
    drive(1'b0, 300);
    @(negedge clk);
    chk("brk/pushes", 32'(push_seen - n0), 32'd1);
    chk("brk/busy",   32'(bus.rx_idle),    32'd0);
    chk("brk/flags",  32'(flag_log.size() > 0 ? flag_log[0] : 3'bxxx), 32'b100);
    flag_log.delete();
    model_push(11'h400);
    chk("brk/entry",  32'(bus.rx_data_out), 32'h400);
    drive(1'b1, 2);
    @(negedge clk);
    chk("brk/idle",   32'(bus.rx_idle),    32'd1);
    wait_ticks(4);
    @(negedge clk);
    chk("brk/once",   32'(push_seen - n0), 32'd1);
    check_fifo("brk");
    pop_fifo();

    // Overrun: 17 frames without popping
    for (int v = 1; v <= 17; v++) begin
      send_and_check($sformatf("ovr%0d", v), 8'(v), 8'h03, 1'b0, 1'b1);
    end
    check_fifo("ovr");
    chk("ovr/count16", 32'(bus.rx_fifo_count), 32'd16);
    chk("ovr/head1",   32'(bus.rx_data_out),   32'h001);
    chk("ovr/flag",    32'(bus.rx_overrun),    32'd1);
    pop_fifo();
    chk("ovr/count15", 32'(bus.rx_fifo_count), 32'd15);
    chk("ovr/head2",   32'(bus.rx_data_out),   32'h002);
    chk("ovr/cleared", 32'(bus.rx_overrun),    32'd0);
    check_fifo("ovrpop");
    @(negedge clk);
    bus.rx_fifo_clear = 1'b1;
    @(negedge clk);
    bus.rx_fifo_clear = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    check_fifo("clear");

    // Start glitch: 3 ticks low
    n0 = push_seen;
    drive(1'b0, 3);
    @(negedge clk);
    chk("glitch/start", 32'(bus.rx_idle), 32'd0);
    drive(1'b1, 7);
    @(negedge clk);
    chk("glitch/idle",   32'(bus.rx_idle),    32'd1);
    chk("glitch/nopush", 32'(push_seen - n0), 32'd0);
    check_fifo("glitch");

    // Randomized frames against the model, in batches
    for (int b = 0; b < 3; b++) begin
      for (int j = 0; j < 5; j++) begin
        lcr = 8'($urandom);
        d   = 8'($urandom);
        send_and_check($sformatf("rnd%0d_%0d", b, j), d, lcr, 1'($urandom),
                       $urandom_range(0, 3) != 0);
      end
      check_fifo($sformatf("rnd%0d", b));
      while (mq.size() > 0) begin
        pop_fifo();
        check_fifo($sformatf("rnd%0dpop", b));
      end
    end

    // 5-bit word
    send_and_check("w5", 8'h1F, 8'h00, 1'b0, 1'b1);
    chk("w5/entry", 32'(bus.rx_data_out), 32'h01F);
    check_fifo("w5");

    // Reset in the middle of a frame, entry 0x01F still in the FIFO
    bus.LCR = 8'h03;
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b1, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    chk("prst/idle",  32'(bus.rx_idle),  32'd1);
    chk("prst/state", 32'(bus.rx_state), 32'(IDLE));
    chk("prst/push",  32'(bus.push_rx_fifo), 32'd0);
    check_fifo("prst");
    @(negedge clk);
    bus.srx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(20);
    send_and_check("post", 8'hC3, 8'h03, 1'b0, 1'b1);
    chk("post/entry", 32'(bus.rx_data_out), 32'h0C3);
    check_fifo("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive front end of the UART: oversamples the serial input using the baud enable from the register file, deframes characters according to LCR, and buffers each character with its error flags in a 16-entry FIFO. Its outputs are `rx_data_out`, the FIFO status, `push_rx_fifo`, `rx_idle`, `rx_overrun` and the error flags, all consumed by the UART register file. It consumes `rx_enable`, `LCR` and `rx_fifo_re` from the register file.

## Interface
Parameters:
- FIFO_DEPTH, 16, RX FIFO entries; must be a power of two, with count width log2(FIFO_DEPTH)+1.
- WORD_W, 11, FIFO entry width: {break, parity_err, framing_err, data[7:0]}.

Ports:
- PCLK  in  1  single clock, rising edge.
- PRESET  in  1  reset, asynchronous, active-high.
- rx_enable  in  1  one-PCLK baud tick, 16x the bit rate.
- LCR  in  8  [1:0] word length 5..8, [3] parity enable, [4] even parity, [5] stick parity; other bits ignored.
- srx  in  1  serial input, asynchronous, idle high.
- rx_fifo_re  in  1  pop pulse.
- rx_fifo_clear  in  1  synchronous FIFO flush (FCR[1] write).
- rx_data_out  out  11  FIFO head entry; 0 when empty.
- rx_fifo_count  out  5  occupancy, 0..16.
- rx_fifo_empty / rx_fifo_full  out  1 each  FIFO status flags.
- push_rx_fifo  out  1  one-cycle pulse per completed frame, whether or not it was stored.
- rx_idle  out  1  FSM in IDLE.
- rx_overrun  out  1  sticky overrun flag.
- parity_error / framing_error / break_error  out  1 each  flags of the frame being pushed, valid with push_rx_fifo.
- rx_state  out  4  FSM state encoding, for debug.

## Operation
- srx passes through a 2-flop synchronizer (reset value 1). All sampling uses the synchronized value `s`.
- All FSM and counter activity advances only on cycles where rx_enable=1. A 4-bit tick counter `cnt` is used.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: on a tick with s=0, go to START with cnt=0.
  - START: on the tick where cnt==7, sample. If s=0, go to DATA with cnt=0. If s=1, the start was a glitch: return to IDLE with nothing pushed.
  - DATA: on the tick where cnt==15, sample the bit, LSB first. After 5+LCR[1:0] bits, go to PARITY if LCR[3]=1, otherwise to STOP. Unused upper data bits are 0.
  - PARITY: sample at cnt==15. Expected parity bit:
    - stick parity (LCR[5]=1): ~LCR[4];
    - else even parity: XOR of the data bits;
    - else odd parity: the complement of that XOR.
    - parity_err = sampled != expected.
  - STOP: sample at cnt==15. framing_err = (s==0). Then push the frame.
    - break: data, parity bit and stop bit were all 0. The entry is then 0x400: parity_err and framing_err are forced to 0.
    - If the stop bit was 1, go to IDLE. Otherwise go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with s=1, then go to IDLE. A held-low line therefore produces exactly one break entry.
- Only the first stop bit is checked; LCR[2] is ignored.
- FIFO priority, highest first:
  - rx_fifo_clear: pointers and count go to 0 and rx_overrun is cleared; any push in the same cycle is lost.
  - Push while full without a pop: the entry is dropped and rx_overrun is set.
  - Push and pop in the same cycle when full: both occur, count stays 16, no overrun.
  - Pop while empty: ignored.
- rx_overrun is cleared on the edge where rx_fifo_re=1. The register file captures the old value on that same edge.
- LCR is sampled live. Changing LCR mid-frame is undefined, and the bench must not do it.

## Timing
- Reset values:
  - FSM in IDLE, so rx_idle=1.
  - rx_state = IDLE encoding.
  - FIFO empty: rx_fifo_empty=1, rx_fifo_full=0, rx_fifo_count=0, rx_data_out=0.
  - push_rx_fifo, rx_overrun and all error flags = 0.
  - Synchronizer flops = 1.
- The start-detect tick is tick 0. The mid-start sample is at tick 8; bit k is sampled at tick 8+16(k+1). For 8N1 the stop bit is sampled at tick 152.
- push_rx_fifo, the error flags and the FIFO write are registered. They are visible in the cycle after the stop-sample tick.
- rx_data_out, rx_fifo_count and the flags update on the edge after push or pop. rx_data_out is driven combinationally from the read pointer.
- Pointers wrap modulo 16.
- PRESET mid-frame aborts the frame at once, with nothing pushed.
- With rx_enable held at 0, the block is frozen.

## Structure
- Package uart_rx_pkg holds:
  - the rx_state_t enum;
  - RX_FIFO_DEPTH=16;
  - entry bit-position constants BRK_BIT=10, PE_BIT=9, FE_BIT=8.
- Sub-module uart_rx_fifo implements the 16x11 storage, pointers, count, clear and overrun logic. The top level holds the synchronizer, tick counter, FSM and parity check.

## Test plan
For all scenarios, rx_enable pulses once every 4 PCLK.
- LCR=0x03, send 0xA5 in 8N1 → one push_rx_fifo pulse, rx_data_out=0x0A5, count=1; after rx_fifo_re: count=0, empty=1.
- LCR=0x1B (even parity), send 0x3C with parity bit 1 → entry 0x23C, parity_error pulse. Resend with parity bit 0 → entry 0x03C.
- LCR=0x03, hold srx low for 300 ticks, then high → exactly one entry, 0x400, with a break_error pulse. FSM reaches IDLE on the first high tick.
- Send 17 frames 0x01..0x11 without popping → count=16, full=1, rx_overrun=1, head=0x001. One rx_fifo_re → count=15, rx_overrun=0, head=0x002.
- srx low for 3 ticks only → no push, and rx_idle returns to 1 by tick 8.
- LCR=0x00 (5-bit word), send 0x1F → entry 0x01F. Assert PRESET halfway through a frame → all outputs return to reset values, and the next clean frame is received correctly.
